cnn_mul_arb_14s_8b: RTL and testbench
=====================================

Name: cnn_mul_arb_14s_8b

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed 14b x 8b multiplier among NUM_REQ conv-layer requesters (e.g. unrolled channel lanes).
- Accepts at most one operand pair per cycle over valid/ready and returns a tagged 22b product on a single response channel with backpressure.
- Sits between the conv2 lane datapaths and the DSP48 multiply resource; the multiply is inferred internally as a registered signed product.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2^ID_W >= NUM_REQ.
- MUL_STAGES, 2, register stages from accept to response (2..4).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*14  flattened signed multiplicands; lane i at [14*i+13:14*i].
- req_b  in  NUM_REQ*8  flattened signed multipliers; lane i at [8*i+7:8*i].
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  22  signed product a*b, full precision.
- rsp_id  out  ID_W  index of the requester that issued the operands.

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_id=0, all stage valid bits=0, rr_ptr=0; req_ready=0 while ap_rst_n=0. Reset mid-operation drops all in-flight products; no response is emitted for them.
- advance = !stage_valid[MUL_STAGES-1] | rsp_ready. Every pipeline stage shifts only when advance=1; the whole pipeline freezes when advance=0.
- Grant is combinational: search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
- req_ready[i] = grant[i] & advance. Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. On a transfer, rr_ptr <= (i+1) mod NUM_REQ; otherwise rr_ptr holds.
- Stage 0 captures a, b, id and valid=1. The signed product is formed in stage 1. Later stages only delay the result.
- Latency: operands accepted at edge t appear on rsp_data/rsp_id with rsp_valid=1 after edge t+MUL_STAGES-1, i.e. MUL_STAGES cycles, absent stalls.
- Throughput: 1 product per cycle.
- Arithmetic: both operands are sign-extended to 22b before multiplying; no overflow is possible. -8192 * -128 = 1048576.
- Stall: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id hold stable and no new request is accepted.
- Bubbles: a cycle with no grant and advance=1 inserts a bubble (stage valid=0). A bubble at the output stage does not block acceptance.
- Simultaneous rsp_ready=1 and a new accept in the same cycle: both occur; the pipeline stays full with no loss.
- No request is starved: any requester held valid is granted within NUM_REQ accepting cycles.

Optional Feature:
- Macro CNN_MUL_ARB_STATS_EN.
- Defined: adds outputs stat_grant_cnt (32b) and stat_stall_cnt (32b), both reset to 0 by ap_rst_n.
  - stat_grant_cnt increments on each request transfer.
  - stat_stall_cnt increments each cycle with rsp_valid=1 and rsp_ready=0.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: req_valid=0001, a=-8192, b=-128, rsp_ready=1 -> exactly 2 cycles later rsp_valid=1, rsp_data=1048576, rsp_id=0, for one cycle only.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one rsp per cycle; rsp_id follows the same order; each product equals its lane's a*b.
- Pointer skip: rr_ptr=3, req_valid=0110 -> req1 granted, then req2; rr_ptr ends at 3.
- Backpressure: pipeline full, rsp_ready=0 for 3 cycles -> rsp_data/rsp_id constant, req_ready=0000. After release, all products are delivered in order with none lost or duplicated.
- Reset mid-operation: ap_rst_n low for 1 cycle with 2 products in flight -> rsp_valid=0 immediately (asynchronous); no stale product after release; first grant goes to req0.
- With CNN_MUL_ARB_STATS_EN: 10 accepted requests and 3 stall cycles -> stat_grant_cnt=10, stat_stall_cnt=3.

Source files
------------

// File: rtl/cnn_mul_arb_14s_8b.sv
// ---------------------------------------------------------------------------
// cnn_mul_arb_14s_8b
//
// Purpose:
//   Shares one pipelined signed 14b x 8b multiplier among NUM_REQ conv-layer
//   requesters. A round-robin arbiter accepts at most one operand pair per
//   cycle. Each product is returned with the tag of its requester on a single
//   response channel that supports backpressure.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   ID_W       requester tag width, 2^ID_W >= NUM_REQ
//   MUL_STAGES register stages from accept to response (2..4)
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   asynchronous reset, active-low
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_a      flattened signed 14b multiplicands, lane i at [14*i+13:14*i]
//   req_b      flattened signed 8b multipliers, lane i at [8*i+7:8*i]
//   rsp_valid  product valid
//   rsp_ready  consumer accept
//   rsp_data   signed 22b product a*b
//   rsp_id     index of the requester that issued the operands
//
// Optional feature (macro CNN_MUL_ARB_STATS_EN):
//   stat_grant_cnt  32b count of request transfers
//   stat_stall_cnt  32b count of cycles with rsp_valid=1 and rsp_ready=0
// ---------------------------------------------------------------------------
module cnn_mul_arb_14s_8b #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_STAGES = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*14-1:0] req_a,
  input  logic [NUM_REQ*8-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [21:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id
`ifdef CNN_MUL_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grant_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [MUL_STAGES-1:0] r_vld;
  logic signed [13:0] r_a0;
  logic signed [7:0]  r_b0;
  logic [ID_W-1:0]    r_id   [MUL_STAGES];
  logic signed [21:0] r_prod [1:MUL_STAGES-1];

  logic               w_advance;
  logic               w_found;
  logic               w_transfer;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gid;
  logic [IDX_W-1:0]   w_next_ptr;
  logic signed [13:0] w_a_sel;
  logic signed [7:0]  w_b_sel;
  logic signed [21:0] w_a_ext;
  logic signed [21:0] w_b_ext;
  logic signed [21:0] w_prod;

  // The pipeline moves only when the output slot is empty or being drained.
  assign w_advance  = !r_vld[MUL_STAGES-1] | rsp_ready;
  assign w_transfer = w_found & w_advance;

  // Round-robin search starting at r_rr_ptr. The outer loop walks the
  // priority order; the inner loop keeps every lane index constant so the
  // operand mux is a plain AND-OR.
  always_comb begin
    w_grant    = '0;
    w_found    = 1'b0;
    w_gid      = '0;
    w_next_ptr = r_rr_ptr;
    w_a_sel    = '0;
    w_b_sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i == (int'(r_rr_ptr) + k) % NUM_REQ) && req_valid[i]) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_gid      = ID_W'(i);
          w_next_ptr = IDX_W'((i + 1) % NUM_REQ);
          w_a_sel    = req_a[14*i +: 14];
          w_b_sel    = req_b[8*i +: 8];
        end
      end
    end
  end

  // Ready is forced low while reset is asserted, even though the grant
  // logic itself is purely combinational.
  assign req_ready = (ap_rst_n && w_advance) ? w_grant : '0;

  // Sign-extend both operands to the full product width before multiplying.
  assign w_a_ext = {{8{r_a0[13]}}, r_a0};
  assign w_b_ext = {{14{r_b0[7]}}, r_b0};
  assign w_prod  = w_a_ext * w_b_ext;

  assign rsp_valid = r_vld[MUL_STAGES-1];
  assign rsp_data  = r_prod[MUL_STAGES-1];
  assign rsp_id    = r_id[MUL_STAGES-1];

  // Stage 0 holds the raw operands, stage 1 the product, and later stages
  // only delay it. A cycle without a transfer shifts in a bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      r_a0     <= '0;
      r_b0     <= '0;
      for (int s = 0; s < MUL_STAGES; s++) r_id[s] <= '0;
      for (int s = 1; s < MUL_STAGES; s++) r_prod[s] <= '0;
    end else if (w_advance) begin
      r_vld <= {r_vld[MUL_STAGES-2:0], w_transfer};
      if (w_transfer) begin
        r_a0     <= w_a_sel;
        r_b0     <= w_b_sel;
        r_id[0]  <= w_gid;
        r_rr_ptr <= w_next_ptr;
      end
      r_prod[1] <= w_prod;
      for (int s = 1; s < MUL_STAGES; s++) r_id[s] <= r_id[s-1];
      for (int s = 2; s < MUL_STAGES; s++) r_prod[s] <= r_prod[s-1];
    end
  end

`ifdef CNN_MUL_ARB_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running statistics counters that wrap naturally at 2^32.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_transfer) r_grant_cnt <= r_grant_cnt + 32'd1;
      if (rsp_valid && !rsp_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stat_grant_cnt = r_grant_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cnn_mul_arb_14s_8b.sv
// ---------------------------------------------------------------------------
// tb_cnn_mul_arb_14s_8b
//
// Purpose:
//   Self-checking bench for cnn_mul_arb_14s_8b. It drives a table of per-cycle
//   request/response-ready vectors with hand-computed expected grants and
//   responses, and then runs a hand-written asynchronous reset sequence.
//   Statistics outputs are checked when CNN_MUL_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cnn_mul_arb_14s_8b;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int MUL_STAGES = 2;

  // Fixed lane operands and their products.
  localparam int P0 = 1048576;   // -8192 * -128
  localparam int P1 = -500;      //   100 *   -5
  localparam int P2 = -2100;     //  -300 *    7
  localparam int P3 = 1040257;   //  8191 *  127

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*14-1:0] req_a = '0;
  logic [NUM_REQ*8-1:0]  req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [21:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
`ifdef CNN_MUL_ARB_STATS_EN
  logic [31:0]           stat_grant_cnt;
  logic [31:0]           stat_stall_cnt;
`endif

  int numCompared = 0;
  int numMismatched = 0;

  typedef struct {
    logic [3:0] reqValid;
    logic       rspReady;
    logic [3:0] expReady;
    logic       expRspValid;
    int         expData;
    logic [1:0] expId;
  } vecT;

  vecT vecs[$];

  always #5 ap_clk = ~ap_clk;

  cnn_mul_arb_14s_8b #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .MUL_STAGES(MUL_STAGES)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef CNN_MUL_ARB_STATS_EN
    ,
    .stat_grant_cnt(stat_grant_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives the handshake inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    #1;
  endtask

  // Advances one clock; outputs are sampled 1 time unit after the edge.
  task automatic stepClock();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [31:0] dataExt(input logic [21:0] d);
    return {{10{d[21]}}, d};
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // lane3 .. lane0
    req_a = {14'(8191), 14'(-300), 14'(100), 14'(-8192)};
    req_b = {8'(127), 8'(7), 8'(-5), 8'(-128)};

    // Reset state, with every requester asking during reset.
    ap_rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    #12;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_data", dataExt(rsp_data), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
`ifdef CNN_MUL_ARB_STATS_EN
    checkOutput("reset stat_grant_cnt", stat_grant_cnt, 32'd0);
    checkOutput("reset stat_stall_cnt", stat_stall_cnt, 32'd0);
`endif
    @(posedge ap_clk);
    #1;
    req_valid = '0;
    ap_rst_n  = 1'b1;

    // Per-cycle vectors: {valid, rsp_ready, exp req_ready, exp rsp_valid, exp data, exp id}.
    // Single request from lane0, visible two cycles later for one cycle.
    vecs.push_back('{4'b0001, 1'b1, 4'b0001, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P0, 2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0,  2'd0});
    // All lanes valid: rotation continues from pointer 1 and wraps.
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0100, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, P1, 2'd1});
    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, P2, 2'd2});
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, P3, 2'd3});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P0, 2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P1, 2'd1});
    // Pointer skip: lane2 moves pointer to 3, then 0110 grants lane1 then lane2.
    vecs.push_back('{4'b0100, 1'b1, 4'b0100, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b0110, 1'b1, 4'b0010, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b0110, 1'b1, 4'b0100, 1'b1, P2, 2'd2});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P1, 2'd1});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P2, 2'd2});
    // Pointer ended at 3: fill the pipeline, then stall for three cycles.
    vecs.push_back('{4'b1111, 1'b1, 4'b1000, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b0, 0,  2'd0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, P3, 2'd3});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, P3, 2'd3});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, P3, 2'd3});
    // Release: drain and accept in the same cycle, then drain in order.
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, P3, 2'd3});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P0, 2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, P1, 2'd1});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 0,  2'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].reqValid, vecs[i].rspReady);
      checkOutput($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].expRspValid));
      if (vecs[i].expRspValid) begin
        checkOutput($sformatf("row%0d rsp_data", i), dataExt(rsp_data), 32'(vecs[i].expData));
        checkOutput($sformatf("row%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].expId));
      end
      stepClock();
    end

`ifdef CNN_MUL_ARB_STATS_EN
    // 12 transfers and 3 stall cycles in the table above.
    checkOutput("stat_grant_cnt", stat_grant_cnt, 32'd12);
    checkOutput("stat_stall_cnt", stat_stall_cnt, 32'd3);
`endif

    // Reset mid-operation with two products in flight (pointer is at 2).
    applyStimulus(4'b1111, 1'b1);
    checkOutput("pre-reset grant lane2", 32'(req_ready), 32'b0100);
    stepClock();
    applyStimulus(4'b1111, 1'b1);
    checkOutput("pre-reset grant lane3", 32'(req_ready), 32'b1000);
    stepClock();
    checkOutput("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("pre-reset rsp_data", dataExt(rsp_data), 32'(P2));
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("async reset req_ready", 32'(req_ready), 32'd0);
`ifdef CNN_MUL_ARB_STATS_EN
    checkOutput("async reset stat_grant_cnt", stat_grant_cnt, 32'd0);
`endif
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    checkOutput("post-reset rsp_valid c0", 32'(rsp_valid), 32'd0);
    stepClock();
    checkOutput("post-reset rsp_valid c1", 32'(rsp_valid), 32'd0);
    stepClock();
    checkOutput("post-reset rsp_valid c2", 32'(rsp_valid), 32'd0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("post-reset first grant", 32'(req_ready), 32'b0001);
    stepClock();
    applyStimulus(4'b0000, 1'b1);
    stepClock();
    checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("post-reset rsp_data", dataExt(rsp_data), 32'(P0));
    checkOutput("post-reset rsp_id", 32'(rsp_id), 32'd0);
    stepClock();
    checkOutput("post-reset single pulse", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
